// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: address map, funct3 codes,
// CSR index type, decode result and FSM state encoding.
package csr_access_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [3:0] MCAUSE_ILLEGAL_INSTR = 4'd2;

    // Index into the 16-entry machine CSR file.
    typedef enum logic [3:0] {
        IDX_MSTATUS  = 4'd0,
        IDX_MISA     = 4'd1,
        IDX_MIE      = 4'd2,
        IDX_MTVEC    = 4'd3,
        IDX_MSCRATCH = 4'd4,
        IDX_MEPC     = 4'd5,
        IDX_MCAUSE   = 4'd6,
        IDX_MTVAL    = 4'd7,
        IDX_MIP      = 4'd8,
        IDX_MCYCLE   = 4'd9,
        IDX_MINSTRET = 4'd10
    } destinationCSR_;

    typedef struct packed {
        destinationCSR_ index;
        logic           legal;
        logic           readonly;
        logic           const_valid;
        logic [31:0]    const_value;
    } csr_decode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_t;

    // True when the instruction writes its CSR: RW forms always do,
    // set/clear forms only with a non-zero rs1/zimm field.
    function automatic logic csr_write_intent(input logic [2:0] funct3,
                                              input logic [4:0] rs1_zimm);
        return (funct3[1:0] == 2'b01) || (rs1_zimm != 5'd0);
    endfunction

endpackage

// File: rtl/csr_access_unit_addr_decode.sv
// Maps a 12-bit CSR address to the CSR file index, or to a constant value
// for the ID registers that have no storage.
module csr_addr_decode
    import csr_access_unit_pkg::*;
#(
    parameter int HART_ID       = 0,
    parameter int USER_COUNTERS = 1
) (
    input  logic [11:0] addr,
    output csr_decode_t dec
);

    // Address lookup; read-only is purely the top two address bits.
    always_comb begin
        dec             = '0;
        dec.index       = IDX_MSTATUS;
        dec.readonly    = (addr[11:10] == 2'b11);
        case (addr)
            CSR_MSTATUS:  begin dec.legal = 1'b1; dec.index = IDX_MSTATUS;  end
            CSR_MISA:     begin dec.legal = 1'b1; dec.index = IDX_MISA;     end
            CSR_MIE:      begin dec.legal = 1'b1; dec.index = IDX_MIE;      end
            CSR_MTVEC:    begin dec.legal = 1'b1; dec.index = IDX_MTVEC;    end
            CSR_MSCRATCH: begin dec.legal = 1'b1; dec.index = IDX_MSCRATCH; end
            CSR_MEPC:     begin dec.legal = 1'b1; dec.index = IDX_MEPC;     end
            CSR_MCAUSE:   begin dec.legal = 1'b1; dec.index = IDX_MCAUSE;   end
            CSR_MTVAL:    begin dec.legal = 1'b1; dec.index = IDX_MTVAL;    end
            CSR_MIP:      begin dec.legal = 1'b1; dec.index = IDX_MIP;      end
            CSR_MCYCLE:   begin dec.legal = 1'b1; dec.index = IDX_MCYCLE;   end
            CSR_MINSTRET: begin dec.legal = 1'b1; dec.index = IDX_MINSTRET; end
            CSR_CYCLE: begin
                dec.legal = (USER_COUNTERS != 0);
                dec.index = IDX_MCYCLE;
            end
            CSR_INSTRET: begin
                dec.legal = (USER_COUNTERS != 0);
                dec.index = IDX_MINSTRET;
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: begin
                dec.legal       = 1'b1;
                dec.const_valid = 1'b1;
                dec.const_value = 32'd0;
            end
            CSR_MHARTID: begin
                dec.legal       = 1'b1;
                dec.const_valid = 1'b1;
                dec.const_value = 32'(HART_ID);
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Execute-stage initiator for Zicsr instructions: decodes the CSR address,
// reads the old value, performs the read-modify-write and returns the old
// value (or an illegal-instruction trap request) to writeback.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepting a request (req_ready=1)
// ST_READ  | read_csr driven, old value captured, new value computed
// ST_WRITE | one-cycle write strobe to dest_csr (suppressed by flush)
// ST_RESP  | rsp_valid held with stable rsp_* until rsp_ready
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int HART_ID       = 0,
    parameter int USER_COUNTERS = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_funct3,
    input  logic [11:0]    req_csr_addr,
    input  logic [31:0]    req_rs1_value,
    input  logic [4:0]     req_rs1_zimm,
    input  logic [4:0]     req_rd,
    input  logic [31:0]    req_instr,
    output destinationCSR_ read_csr,
    input  logic [31:0]    csr_read_data,
    output destinationCSR_ dest_csr,
    output logic [31:0]    csr_write_data,
    output logic           csr_write_enable,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [4:0]     rsp_rd,
    output logic [31:0]    rsp_data,
    output logic           rsp_illegal,
    output logic [3:0]     rsp_mcause,
    output logic [31:0]    rsp_mtval
);

    csr_state_t     state_q, state_d;
    csr_decode_t    dec;

    logic           accept;
    logic           req_write;
    logic           req_illegal;
    logic [31:0]    req_operand;
    logic [31:0]    old_value;
    logic [31:0]    merged_value;

    logic [1:0]     op_kind_q;
    logic [31:0]    operand_q;
    logic [4:0]     rd_q;
    logic [31:0]    instr_q;
    destinationCSR_ index_q;
    logic           const_valid_q;
    logic [31:0]    const_value_q;
    logic           illegal_q;
    logic           write_q;
    logic [31:0]    old_q;
    logic [31:0]    new_q;

    csr_addr_decode #(
        .HART_ID       (HART_ID),
        .USER_COUNTERS (USER_COUNTERS)
    ) u_addr_decode (
        .addr (req_csr_addr),
        .dec  (dec)
    );

    // Request-side decode: operand select, write intent and legality.
    always_comb begin
        accept      = (state_q == ST_IDLE) && req_valid && !flush;
        req_write   = csr_write_intent(req_funct3, req_rs1_zimm);
        req_illegal = (req_funct3[1:0] == 2'b00) || !dec.legal ||
                      (req_write && dec.readonly);
        req_operand = req_funct3[2] ? {27'd0, req_rs1_zimm} : req_rs1_value;
    end

    // Old value (constant CSRs never touch the file) and the RMW result.
    always_comb begin
        old_value = const_valid_q ? const_value_q : csr_read_data;
        case (op_kind_q)
            2'b01:   merged_value = operand_q;
            2'b10:   merged_value = old_value | operand_q;
            default: merged_value = old_value & ~operand_q;
        endcase
    end

    // Capture the instruction on acceptance and the old/new values in READ.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_kind_q     <= 2'b00;
            operand_q     <= '0;
            rd_q          <= '0;
            instr_q       <= '0;
            index_q       <= IDX_MSTATUS;
            const_valid_q <= 1'b0;
            const_value_q <= '0;
            illegal_q     <= 1'b0;
            write_q       <= 1'b0;
            old_q         <= '0;
            new_q         <= '0;
        end else begin
            if (accept) begin
                op_kind_q     <= req_funct3[1:0];
                operand_q     <= req_operand;
                rd_q          <= req_rd;
                instr_q       <= req_instr;
                index_q       <= dec.index;
                const_valid_q <= dec.const_valid;
                const_value_q <= dec.const_value;
                illegal_q     <= req_illegal;
                write_q       <= req_write;
                old_q         <= '0;
            end
            if (state_q == ST_READ) begin
                old_q <= old_value;
                new_q <= merged_value;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and outputs; flush forces IDLE from any state.
    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        read_csr         = IDX_MSTATUS;
        dest_csr         = IDX_MSTATUS;
        csr_write_data   = '0;
        csr_write_enable = 1'b0;
        rsp_valid        = 1'b0;
        rsp_rd           = '0;
        rsp_data         = '0;
        rsp_illegal      = 1'b0;
        rsp_mcause       = '0;
        rsp_mtval        = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) state_d = req_illegal ? ST_RESP : ST_READ;
            end
            ST_READ: begin
                read_csr = index_q;
                state_d  = write_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                dest_csr         = index_q;
                csr_write_data   = new_q;
                // A sync reset in this cycle must not leak a strobe either.
                csr_write_enable = !flush && !reset;
                state_d          = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid   = 1'b1;
                rsp_rd      = rd_q;
                rsp_data    = illegal_q ? 32'd0 : old_q;
                rsp_illegal = illegal_q;
                rsp_mcause  = illegal_q ? MCAUSE_ILLEGAL_INSTR : 4'd0;
                rsp_mtval   = illegal_q ? instr_q : 32'd0;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

endmodule
